// File: rtl/zbb_bitcnt_seq.sv
// ---------------------------------------------------------------------------
// zbb_bitcnt_seq
//   Multi-cycle Zbb bit-count responder (clz, ctz, cpop on rs1). Scans CHUNK
//   bits of the operand per BUSY cycle, MSB first, so a 32-bit op with
//   CHUNK=4 takes 8 scan cycles plus one cycle to present the result.
//
// Parameters
//   XLEN   operand/result width
//   CHUNK  bits scanned per BUSY cycle; must divide XLEN
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high (priority over kill)
//   kill         in   synchronous abort of any in-flight op / pending result
//   req_valid    in   request present
//   req_ready    out  unit can accept a request (IDLE only)
//   req_op       in   00 clz, 01 ctz, 10 cpop, 11 reserved
//   req_rs1      in   operand
//   rsp_valid    out  result available (DONE only)
//   rsp_ready    in   core accepts result
//   rsp_data     out  zero-extended count
//   rsp_illegal  out  op was reserved; rsp_data is 0
//
// Configuration
//   ZBB_BITCNT_EARLY_EXIT_EN  when defined, clz/ctz finish in the BUSY cycle
//   that finds the first set bit and cpop finishes once the remaining shift
//   register is zero. Results are identical; only latency changes.
// ---------------------------------------------------------------------------
module zbb_bitcnt_seq #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_illegal
);

    localparam int NBEAT = XLEN / CHUNK;
    localparam int CW    = $clog2(XLEN) + 1;
    localparam int BW    = $clog2(NBEAT + 1);

    generate
        if ((XLEN % CHUNK) != 0) begin : g_bad_chunk
            $error("zbb_bitcnt_seq: CHUNK must divide XLEN");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_CLZ  = 2'b00,
        OP_CTZ  = 2'b01,
        OP_CPOP = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    state_e          state;
    op_e             op_q;
    logic [XLEN-1:0] sreg;
    logic [CW-1:0]   cnt;
    logic            found;
    logic [BW-1:0]   beat;

    logic [XLEN-1:0] rs1_rev;
    logic [XLEN-1:0] sreg_shift;
    logic [CHUNK-1:0] bits;
    logic [CW-1:0]   nxt_cnt;
    logic            nxt_found;
    logic            last_beat;
    logic            done_now;

    // ctz is turned into a leading-zero scan by reversing the operand.
    always_comb begin
        rs1_rev = {<<{req_rs1}};
    end

    always_comb begin
        sreg_shift = sreg << CHUNK;
    end

    // One chunk of scan work: walk the top CHUNK bits MSB first by shifting a
    // local copy, so every bit access uses a constant index.
    always_comb begin
        bits      = sreg[XLEN-1 -: CHUNK];
        nxt_cnt   = cnt;
        nxt_found = found;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (op_q == OP_CPOP) begin
                if (bits[CHUNK-1]) begin
                    nxt_cnt = nxt_cnt + CW'(1);
                end
            end else if (!nxt_found && !bits[CHUNK-1]) begin
                nxt_cnt = nxt_cnt + CW'(1);
            end else begin
                nxt_found = 1'b1;
            end
            bits = bits << 1;
        end
    end

    always_comb begin
        last_beat = (beat == BW'(NBEAT - 1));
`ifdef ZBB_BITCNT_EARLY_EXIT_EN
        if (op_q == OP_CPOP) begin
            done_now = last_beat || (sreg_shift == '0);
        end else begin
            done_now = last_beat || nxt_found;
        end
`else
        done_now = last_beat;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_CLZ;
            sreg        <= '0;
            cnt         <= '0;
            found       <= 1'b0;
            beat        <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_illegal <= 1'b0;
        end else if (kill) begin
            // Abort wins over any handshake in the same cycle.
            state       <= IDLE;
            cnt         <= '0;
            found       <= 1'b0;
            beat        <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q      <= op_e'(req_op);
                        sreg      <= (op_e'(req_op) == OP_CTZ) ? rs1_rev : req_rs1;
                        cnt       <= '0;
                        found     <= 1'b0;
                        beat      <= '0;
                        req_ready <= 1'b0;
                        if (op_e'(req_op) == OP_RSVD) begin
                            state       <= DONE;
                            rsp_valid   <= 1'b1;
                            rsp_data    <= '0;
                            rsp_illegal <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt   <= nxt_cnt;
                    found <= nxt_found;
                    sreg  <= sreg_shift;
                    beat  <= beat + BW'(1);
                    if (done_now) begin
                        state       <= DONE;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= XLEN'(nxt_cnt);
                        rsp_illegal <= 1'b0;
                    end
                end
                DONE: begin
                    // Return to IDLE only; a new request waits for the next cycle.
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zbb_bitcnt_seq.sv
module tb_zbb_bitcnt_seq;

    localparam int XLEN = 32;
    localparam int NI   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            kill = 1'b0;
    logic            rsp_ready = 1'b0;
    logic [1:0]      req_op = 2'b00;
    logic [XLEN-1:0] req_rs1 = '0;
    logic            req_valid_v [NI] = '{default: 1'b0};
    logic            req_ready_w [NI];
    logic            rsp_valid_w [NI];
    logic [XLEN-1:0] rsp_data_w  [NI];
    logic            rsp_ill_w   [NI];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        zbb_bitcnt_seq #(
            .XLEN (XLEN),
            .CHUNK((g == 0) ? 1 : ((g == 1) ? 4 : 8))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .kill       (kill),
            .req_valid  (req_valid_v[g]),
            .req_ready  (req_ready_w[g]),
            .req_op     (req_op),
            .req_rs1    (req_rs1),
            .rsp_valid  (rsp_valid_w[g]),
            .rsp_ready  (rsp_ready),
            .rsp_data   (rsp_data_w[g]),
            .rsp_illegal(rsp_ill_w[g])
        );
    end

    typedef struct {
        logic [31:0] data;
        logic        ill;
        int          k;
        int          beats;
    } item_t;

    item_t       sbq [NI][$];
    bit          seen      [NI];
    int          first_cyc [NI];
    logic [31:0] held_data [NI];
    logic        held_ill  [NI];

    int tests = 0;
    int fails = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string nm);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic int chunk_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
    endfunction

    function automatic int ref_clz(logic [31:0] x);
        logic [31:0] t = x;
        int n = 0;
        while (n < 32 && !t[31]) begin
            t = t << 1;
            n++;
        end
        return n;
    endfunction

    function automatic int ref_ctz(logic [31:0] x);
        logic [31:0] t = x;
        int n = 0;
        while (n < 32 && !t[0]) begin
            t = t >> 1;
            n++;
        end
        return n;
    endfunction

    function automatic int ref_cpop(logic [31:0] x);
        logic [31:0] t = x;
        int n = 0;
        for (int b = 0; b < 32; b++) begin
            if (t[0]) n++;
            t = t >> 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] ref_data(logic [1:0] op, logic [31:0] x);
        case (op)
            2'b00:   return 32'(ref_clz(x));
            2'b01:   return 32'(ref_ctz(x));
            2'b10:   return 32'(ref_cpop(x));
            default: return 32'h0;
        endcase
    endfunction

    // Number of edges from acceptance to rsp_valid being visible.
    function automatic int ref_beats(int inst, logic [1:0] op, logic [31:0] x);
        int c  = chunk_of(inst);
        int nb = XLEN / c;
        if (op == 2'b11) return 0;
`ifdef ZBB_BITCNT_EARLY_EXIT_EN
        case (op)
            2'b00:   return (x == 0) ? nb : ref_clz(x) / c + 1;
            2'b01:   return (x == 0) ? nb : ref_ctz(x) / c + 1;
            default: return (x == 0) ? 1 : (XLEN - ref_ctz(x) + c - 1) / c;
        endcase
`else
        return nb;
`endif
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst || kill) begin
                    seen[i] = 1'b0;
                    continue;
                end
                if (rsp_valid_w[i]) begin
                    if (!seen[i]) begin
                        seen[i]      = 1'b1;
                        first_cyc[i] = cyc;
                        held_data[i] = rsp_data_w[i];
                        held_ill[i]  = rsp_ill_w[i];
                    end else begin
                        chk("stable_data", rsp_data_w[i], held_data[i]);
                        chk("stable_illegal", 32'(rsp_ill_w[i]), 32'(held_ill[i]));
                    end
                    if (rsp_ready) begin
                        if (sbq[i].size() == 0) begin
                            chk("unexpected_rsp_valid", 32'(rsp_valid_w[i]), 32'h0);
                        end else begin
                            it = sbq[i].pop_front();
                            chk("rsp_data", rsp_data_w[i], it.data);
                            chk("rsp_illegal", 32'(rsp_ill_w[i]), 32'(it.ill));
                            chk("latency", 32'(first_cyc[i]), 32'(it.k + it.beats));
                        end
                        seen[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int inst, logic [1:0] op, logic [31:0] x, bit push);
        item_t it;
        req_op  = op;
        req_rs1 = x;
        req_valid_v[inst] = 1'b1;
        for (int w = 0; w < 200; w++) begin
            if (req_ready_w[inst]) begin
                if (push) begin
                    it.data  = ref_data(op, x);
                    it.ill   = (op == 2'b11);
                    it.k     = cyc + 1;
                    it.beats = ref_beats(inst, op, x);
                    sbq[inst].push_back(it);
                end
                tick();
                req_valid_v[inst] = 1'b0;
                req_op  = 2'($urandom);
                req_rs1 = $urandom;
                return;
            end
            tick();
        end
        fail_now("issue_timeout");
        req_valid_v[inst] = 1'b0;
    endtask

    task automatic drain(int inst, bit rand_rdy);
        for (int w = 0; w < 300; w++) begin
            if (sbq[inst].size() == 0) return;
            if (rand_rdy) rsp_ready = ($urandom % 3) != 0;
            tick();
        end
        fail_now("drain_timeout");
        sbq[inst].delete();
    endtask

    task automatic wait_valid(int inst);
        for (int w = 0; w < 100; w++) begin
            if (rsp_valid_w[inst]) return;
            tick();
        end
        fail_now("wait_valid_timeout");
    endtask

    task automatic chk_reset_vals(string nm, int inst);
        chk({nm, "_req_ready"}, 32'(req_ready_w[inst]), 32'h1);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid_w[inst]), 32'h0);
        chk({nm, "_rsp_data"}, rsp_data_w[inst], 32'h0);
        chk({nm, "_rsp_illegal"}, 32'(rsp_ill_w[inst]), 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit saw;
        logic [1:0]  op;
        logic [31:0] x;
        int          inst;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) chk_reset_vals("reset", i);

        // Directed tests on the CHUNK=4 instance.
        rsp_ready = 1'b1;
        issue(1, 2'b00, 32'h0001_0000, 1); drain(1, 0);
        issue(1, 2'b01, 32'h0000_0000, 1); drain(1, 0);
        issue(1, 2'b10, 32'hF0F0_00FF, 1); drain(1, 0);
        issue(1, 2'b10, 32'hFFFF_FFFF, 1); drain(1, 0);
        issue(1, 2'b11, 32'h0000_1234, 1); drain(1, 0);

        // Backpressure: result held, no new request taken until after handshake.
        rsp_ready = 1'b0;
        issue(1, 2'b10, 32'hF0F0_00FF, 1);
        wait_valid(1);
        req_valid_v[1] = 1'b1;
        req_op  = 2'b00;
        req_rs1 = 32'h0001_0000;
        repeat (5) begin
            chk("hold_valid", 32'(rsp_valid_w[1]), 32'h1);
            chk("hold_data", rsp_data_w[1], 32'd16);
            chk("hold_req_ready", 32'(req_ready_w[1]), 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("post_hs_req_ready", 32'(req_ready_w[1]), 32'h1);
        chk("post_hs_rsp_valid", 32'(rsp_valid_w[1]), 32'h0);
        issue(1, 2'b00, 32'h0001_0000, 1);
        drain(1, 0);

        // Kill during the third BUSY cycle.
        issue(1, 2'b00, 32'h0000_FFFF, 0);
        tick();
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_busy_req_ready", 32'(req_ready_w[1]), 32'h1);
        saw = 1'b0;
        repeat (12) begin
            if (rsp_valid_w[1]) saw = 1'b1;
            tick();
        end
        chk("kill_busy_no_rsp", 32'(saw), 32'h0);
        issue(1, 2'b00, 32'h8000_0000, 1); drain(1, 0);

        // Kill together with rsp_ready in DONE drops the result.
        rsp_ready = 1'b0;
        issue(1, 2'b10, 32'h0000_00FF, 0);
        wait_valid(1);
        rsp_ready = 1'b1;
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_done_rsp_valid", 32'(rsp_valid_w[1]), 32'h0);
        chk("kill_done_req_ready", 32'(req_ready_w[1]), 32'h1);
        repeat (3) tick();

        // Reset mid-BUSY, then reset together with kill.
        issue(1, 2'b10, 32'hFFFF_FFFF, 1); drain(1, 0);
        issue(1, 2'b01, 32'h0000_0100, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst_busy", 1);
        issue(1, 2'b10, 32'h0000_00AA, 1); drain(1, 0);
        issue(1, 2'b00, 32'h0000_0001, 0);
        tick();
        rst  = 1'b1;
        kill = 1'b1;
        tick();
        rst  = 1'b0;
        kill = 1'b0;
        chk_reset_vals("rst_kill", 1);

        // Randomised ops across CHUNK=1,4,8 instances with occasional kills.
        for (int n = 0; n < 1000; n++) begin
            inst = n % NI;
            op   = 2'($urandom % 4);
            case ($urandom % 6)
                0:       x = $urandom;
                1:       x = 32'h0;
                2:       x = 32'hFFFF_FFFF;
                3:       x = 32'h1 << ($urandom % 32);
                4:       x = $urandom & $urandom & $urandom;
                default: x = $urandom >> ($urandom % 32);
            endcase
            rsp_ready = ($urandom % 3) != 0;
            issue(inst, op, x, 1);
            if (($urandom % 12) == 0) begin
                repeat ($urandom % 12) begin
                    rsp_ready = ($urandom % 3) != 0;
                    tick();
                end
                if (sbq[inst].size() != 0) begin
                    kill = 1'b1;
                    tick();
                    kill = 1'b0;
                    sbq[inst].delete();
                end
            end else begin
                drain(inst, 1);
            end
        end

        rsp_ready = 1'b1;
        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        fail_now("global_watchdog");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
